// File: rtl/tictactoe_move_entry.sv
// tictactoe_move_entry
//   Input stage for the tic-tac-toe game core. Five raw push-buttons are
//   synchronised and debounced. Debounced press events move a 0..2 cursor,
//   and a select press produces a single-cycle enter strobe. The cursor is
//   frozen around the strobe so the core samples the position the player
//   confirmed.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   btn_up     in   raw button, row-1
//   btn_down   in   raw button, row+1
//   btn_left   in   raw button, column-1
//   btn_right  in   raw button, column+1
//   btn_sel    in   raw button, confirm move
//   game_over  in   high while the core reports a result; blocks enter
//   row        out  cursor row, 0..2
//   column     out  cursor column, 0..2
//   enter      out  one-cycle move strobe
//
// Build option
//   CURSOR_WRAP_EN  defined: cursor wraps at the board edges (2+1->0, 0-1->2)
//                   undefined: cursor saturates (2+1->2, 0-1->0)

module tictactoe_move_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       game_over,
  output logic [1:0] row,
  output logic [1:0] column,
  output logic       enter
);

  localparam int NB     = 5;
  localparam int B_UP   = 0;
  localparam int B_DOWN = 1;
  localparam int B_LEFT = 2;
  localparam int B_RGT  = 3;
  localparam int B_SEL  = 4;

  // The counter value seen on the last disagreeing sample before the flip.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2
  } sel_state_e;

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    sync0_q, sync0_d;
  logic [NB-1:0]    sync1_q, sync1_d;
  logic [NB-1:0]    deb_q, deb_d;
  logic [NB-1:0]    press_q, press_d;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];

  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  sel_state_e       state_q, state_d;
  logic             enter_q, enter_d;
  logic             take_sel;
  logic             move_ok;

  assign btn_raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  function automatic logic [1:0] cur_inc(input logic [1:0] v);
`ifdef CURSOR_WRAP_EN
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
`else
    return (v == 2'd2) ? 2'd2 : v + 2'd1;
`endif
  endfunction

  function automatic logic [1:0] cur_dec(input logic [1:0] v);
`ifdef CURSOR_WRAP_EN
    return (v == 2'd0) ? 2'd2 : v - 2'd1;
`else
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
`endif
  endfunction

  // Synchronisers and debouncers. press_d marks the cycle the debounced
  // level rises; it is registered so the event lives for exactly one cycle.
  always_comb begin
    sync0_d = btn_raw;
    sync1_d = sync0_q;
    deb_d   = deb_q;
    press_d = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync1_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i]   = sync1_q[i];
          press_d[i] = sync1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A sel press taken in IDLE wins over any move in the same cycle, and the
  // cursor stays frozen through PULSE so enter reports the pressed position.
  assign take_sel = (state_q == S_IDLE) && press_q[B_SEL] && !game_over;
  assign move_ok  = (state_q != S_PULSE) && !take_sel;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (move_ok) begin
      if (press_q[B_DOWN] && !press_q[B_UP])
        row_d = cur_inc(row_q);
      else if (press_q[B_UP] && !press_q[B_DOWN])
        row_d = cur_dec(row_q);
      if (press_q[B_RGT] && !press_q[B_LEFT])
        col_d = cur_inc(col_q);
      else if (press_q[B_LEFT] && !press_q[B_RGT])
        col_d = cur_dec(col_q);
    end
  end

  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (take_sel) begin
          state_d = S_PULSE;
          enter_d = 1'b1;
        end
      end
      S_PULSE: state_d = S_WAIT;
      S_WAIT:  if (!deb_q[B_SEL]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q <= '0;
      sync1_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
      state_q <= S_IDLE;
      enter_q <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      row_q   <= row_d;
      col_q   <= col_d;
      state_q <= state_d;
      enter_q <= enter_d;
    end
  end

  assign row    = row_q;
  assign column = col_q;
  assign enter  = enter_q;

endmodule
